// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: bundle of LSQ, dcachemem and memory-bus signals for dcache_ctrl.
// Ports: master = controller side, slave = LSQ / cache array / memory side.
interface dcache_ctrl_if #(
    parameter int IDX_BITS = 5,
    parameter int TAG_BITS = 56
);
    logic                lsq_req_valid;
    logic                lsq_req_store;
    logic [63:0]         lsq_req_addr;
    logic [63:0]         lsq_req_data;
    logic                lsq_req_ready;
    logic                lsq_resp_valid;
    logic [63:0]         lsq_resp_data;

    logic                cache_en;
    logic [IDX_BITS-1:0] cache_rd_idx;
    logic [TAG_BITS-1:0] cache_rd_tag;
    logic [63:0]         cache_rd_data;
    logic                cache_rd_valid;
    logic                cache_wr_en;
    logic [IDX_BITS-1:0] cache_wr_idx;
    logic [TAG_BITS-1:0] cache_wr_tag;
    logic [63:0]         cache_wr_data;

    logic [1:0]          proc2mem_command;
    logic [63:0]         proc2mem_addr;
    logic [63:0]         proc2mem_data;
    logic [3:0]          mem2proc_response;
    logic [63:0]         mem2proc_data;
    logic [3:0]          mem2proc_tag;

    modport master (
        input  lsq_req_valid, lsq_req_store, lsq_req_addr, lsq_req_data,
        output lsq_req_ready, lsq_resp_valid, lsq_resp_data,
        output cache_en, cache_rd_idx, cache_rd_tag,
        input  cache_rd_data, cache_rd_valid,
        output cache_wr_en, cache_wr_idx, cache_wr_tag, cache_wr_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );

    modport slave (
        output lsq_req_valid, lsq_req_store, lsq_req_addr, lsq_req_data,
        input  lsq_req_ready, lsq_resp_valid, lsq_resp_data,
        input  cache_en, cache_rd_idx, cache_rd_tag,
        output cache_rd_data, cache_rd_valid,
        input  cache_wr_en, cache_wr_idx, cache_wr_tag, cache_wr_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: single-outstanding-request data-cache controller (LSQ <-> dcachemem <-> memory bus).
// Ports: clock, reset (sync, active-high), bus (dcache_ctrl_if.master). Option: DCACHE_WRITE_ALLOCATE_EN.
module dcache_ctrl #(
    parameter int IDX_BITS = 5,
    parameter int TAG_BITS = 56
) (
    input  logic          clock,
    input  logic          reset,
    dcache_ctrl_if.master bus
);
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEMREQ,
        S_WAIT
    } state_t;

    state_t      state;
    logic        r_store;
    logic [63:3] r_addr;
    logic [63:0] r_data;
    logic [3:0]  r_mtag;
`ifndef DCACHE_WRITE_ALLOCATE_EN
    logic        r_hit;
`endif

    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic                mem_acc;
    logic                fill;
    logic                st_wr;

    assign idx     = r_addr[IDX_BITS+2:3];
    assign tag     = r_addr[63:IDX_BITS+3];
    assign mem_acc = bus.mem2proc_response != 4'd0;
    // r_mtag is 0 whenever no load is waiting, so a stray tag never matches.
    assign fill    = (bus.mem2proc_tag != 4'd0) && (bus.mem2proc_tag == r_mtag);
`ifdef DCACHE_WRITE_ALLOCATE_EN
    assign st_wr   = 1'b1;
`else
    assign st_wr   = r_hit;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            r_store <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_mtag  <= '0;
`ifndef DCACHE_WRITE_ALLOCATE_EN
            r_hit   <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.lsq_req_valid) begin
                        r_store <= bus.lsq_req_store;
                        r_addr  <= bus.lsq_req_addr[63:3];
                        r_data  <= bus.lsq_req_data;
                        r_mtag  <= '0;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
`ifndef DCACHE_WRITE_ALLOCATE_EN
                    r_hit <= bus.cache_rd_valid;
`endif
                    if (!r_store && bus.cache_rd_valid) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_MEMREQ;
                    end
                end
                S_MEMREQ: begin
                    if (mem_acc) begin
                        if (r_store) begin
                            state <= S_IDLE;
                        end else begin
                            r_mtag <= bus.mem2proc_response;
                            state  <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (fill) begin
                        r_mtag <= '0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.lsq_req_ready    = 1'b0;
        bus.lsq_resp_valid   = 1'b0;
        bus.lsq_resp_data    = '0;
        bus.cache_en         = 1'b0;
        bus.cache_rd_idx     = idx;
        bus.cache_rd_tag     = tag;
        bus.cache_wr_en      = 1'b0;
        bus.cache_wr_idx     = idx;
        bus.cache_wr_tag     = tag;
        bus.cache_wr_data    = r_data;
        bus.proc2mem_command = CMD_NONE;
        bus.proc2mem_addr    = {r_addr, 3'b000};
        bus.proc2mem_data    = r_data;
        // Outputs already show the idle view while reset is held.
        if (reset) begin
            bus.lsq_req_ready = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    bus.lsq_req_ready = 1'b1;
                end
                S_LOOKUP: begin
                    bus.cache_en = 1'b1;
                    if (!r_store && bus.cache_rd_valid) begin
                        bus.lsq_resp_valid = 1'b1;
                        bus.lsq_resp_data  = bus.cache_rd_data;
                    end
                end
                S_MEMREQ: begin
                    bus.proc2mem_command = r_store ? CMD_STORE : CMD_LOAD;
                    if (mem_acc && r_store) begin
                        bus.lsq_resp_valid = 1'b1;
                        if (st_wr) begin
                            bus.cache_en    = 1'b1;
                            bus.cache_wr_en = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (fill) begin
                        bus.cache_en       = 1'b1;
                        bus.cache_wr_en    = 1'b1;
                        bus.cache_wr_data  = bus.mem2proc_data;
                        bus.lsq_resp_valid = 1'b1;
                        bus.lsq_resp_data  = bus.mem2proc_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with a behavioural dcachemem model.
// Drives LSQ and memory bus by hand, checks bus/cache outputs cycle by cycle.
module tb_dcache_ctrl;
`ifdef DCACHE_WRITE_ALLOCATE_EN
    localparam bit WA = 1'b1;
`else
    localparam bit WA = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [63:0] sb[$];

    always #5 clock = ~clock;

    dcache_ctrl_if #(.IDX_BITS(5), .TAG_BITS(56)) bus ();

    dcache_ctrl #(.IDX_BITS(5), .TAG_BITS(56)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    logic        cv [32] = '{default: 1'b0};
    logic [55:0] ct [32];
    logic [63:0] cd [32];
    int          wr_cnt = 0;

    always_comb begin
        bus.cache_rd_valid = cv[bus.cache_rd_idx] && (ct[bus.cache_rd_idx] == bus.cache_rd_tag);
        bus.cache_rd_data  = cd[bus.cache_rd_idx];
    end

    always @(posedge clock) begin
        if (bus.cache_en && bus.cache_wr_en) begin
            cv[bus.cache_wr_idx] <= 1'b1;
            ct[bus.cache_wr_idx] <= bus.cache_wr_tag;
            cd[bus.cache_wr_idx] <= bus.cache_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (bus.lsq_resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("resp_unexp", 64'd1, 64'd0);
            end else begin
                check("resp_data", bus.lsq_resp_data, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic req(logic st, logic [63:0] a, logic [63:0] d);
        bus.lsq_req_valid = 1'b1;
        bus.lsq_req_store = st;
        bus.lsq_req_addr  = a;
        bus.lsq_req_data  = d;
        smp();
        check("req_ready", {63'd0, bus.lsq_req_ready}, 64'd1);
        step();
        bus.lsq_req_valid = 1'b0;
        bus.lsq_req_store = 1'b0;
    endtask

    task automatic load_hit(logic [63:0] a, logic [63:0] exp);
        sb.push_back(exp);
        req(1'b0, a, 64'd0);
        smp();
        check("hit_resp", {63'd0, bus.lsq_resp_valid}, 64'd1);
        check("hit_cmd", {62'd0, bus.proc2mem_command}, 64'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int wc;

    initial begin
        reset                 = 1'b1;
        bus.lsq_req_valid     = 1'b0;
        bus.lsq_req_store     = 1'b0;
        bus.lsq_req_addr      = '0;
        bus.lsq_req_data      = '0;
        bus.mem2proc_response = '0;
        bus.mem2proc_data     = '0;
        bus.mem2proc_tag      = '0;
        smp();
        check("rst_ready", {63'd0, bus.lsq_req_ready}, 64'd1);
        check("rst_cmd", {62'd0, bus.proc2mem_command}, 64'd0);
        check("rst_resp", {63'd0, bus.lsq_resp_valid}, 64'd0);
        step();
        smp();
        check("rst_cen", {63'd0, bus.cache_en}, 64'd0);
        step();
        reset = 1'b0;

        // load miss on 0x1000, data after 5 cycles
        sb.push_back(64'hDEAD);
        req(1'b0, 64'h1000, 64'd0);
        smp();
        check("lk_en", {63'd0, bus.cache_en}, 64'd1);
        check("lk_idx", {59'd0, bus.cache_rd_idx}, 64'd0);
        check("lk_ready", {63'd0, bus.lsq_req_ready}, 64'd0);
        check("lk_cmd", {62'd0, bus.proc2mem_command}, 64'd0);
        check("lk_wr", {63'd0, bus.cache_wr_en}, 64'd0);
        step();
        bus.mem2proc_response = 4'd3;
        smp();
        check("miss_cmd", {62'd0, bus.proc2mem_command}, 64'd1);
        check("miss_addr", bus.proc2mem_addr, 64'h1000);
        step();
        bus.mem2proc_response = 4'd0;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("wait_cmd", {62'd0, bus.proc2mem_command}, 64'd0);
            check("wait_resp", {63'd0, bus.lsq_resp_valid}, 64'd0);
            step();
        end
        bus.mem2proc_tag  = 4'd3;
        bus.mem2proc_data = 64'hDEAD;
        smp();
        check("fill_wr", {63'd0, bus.cache_wr_en}, 64'd1);
        check("fill_idx", {59'd0, bus.cache_wr_idx}, 64'd0);
        check("fill_resp", {63'd0, bus.lsq_resp_valid}, 64'd1);
        step();
        bus.mem2proc_tag  = 4'd0;
        bus.mem2proc_data = 64'd0;
        check("fill_data", cd[0], 64'hDEAD);
        load_hit(64'h1000, 64'hDEAD);

        // store that hits is written in both configurations
        sb.push_back(64'd0);
        req(1'b1, 64'h1000, 64'h99);
        smp();
        check("st_lk_wr", {63'd0, bus.cache_wr_en}, 64'd0);
        step();
        bus.mem2proc_response = 4'd2;
        smp();
        check("st_cmd", {62'd0, bus.proc2mem_command}, 64'd2);
        check("st_data", bus.proc2mem_data, 64'h99);
        check("st_hit_wr", {63'd0, bus.cache_wr_en}, 64'd1);
        step();
        bus.mem2proc_response = 4'd0;
        load_hit(64'h1000, 64'h99);

        // bus rejects three times, then a wrong tag, then the right one
        sb.push_back(64'hBEEF);
        req(1'b0, 64'h3010, 64'd0);
        smp();
        step();
        for (int i = 0; i < 3; i++) begin
            smp();
            check("rej_cmd", {62'd0, bus.proc2mem_command}, 64'd1);
            check("rej_addr", bus.proc2mem_addr, 64'h3010);
            step();
        end
        bus.mem2proc_response = 4'd5;
        smp();
        check("acc_cmd", {62'd0, bus.proc2mem_command}, 64'd1);
        step();
        bus.mem2proc_response = 4'd0;
        bus.mem2proc_tag      = 4'd2;
        bus.mem2proc_data     = 64'hBAD;
        smp();
        check("bad_tag_resp", {63'd0, bus.lsq_resp_valid}, 64'd0);
        check("bad_tag_wr", {63'd0, bus.cache_wr_en}, 64'd0);
        step();
        bus.mem2proc_tag  = 4'd5;
        bus.mem2proc_data = 64'hBEEF;
        smp();
        check("tag_resp", {63'd0, bus.lsq_resp_valid}, 64'd1);
        check("tag_wr", {63'd0, bus.cache_wr_en}, 64'd1);
        check("tag_idx", {59'd0, bus.cache_wr_idx}, 64'd2);
        step();
        bus.mem2proc_tag  = 4'd0;
        bus.mem2proc_data = 64'd0;

        // store to a cold line
        sb.push_back(64'd0);
        req(1'b1, 64'h2008, 64'h55);
        smp();
        step();
        bus.mem2proc_response = 4'd1;
        smp();
        check("cold_cmd", {62'd0, bus.proc2mem_command}, 64'd2);
        check("cold_addr", bus.proc2mem_addr, 64'h2008);
        check("cold_wr", {63'd0, bus.cache_wr_en}, {63'd0, WA});
        step();
        bus.mem2proc_response = 4'd0;
`ifdef DCACHE_WRITE_ALLOCATE_EN
        load_hit(64'h2008, 64'h55);
`else
        sb.push_back(64'h77);
        req(1'b0, 64'h2008, 64'd0);
        smp();
        check("cold_ld_resp", {63'd0, bus.lsq_resp_valid}, 64'd0);
        step();
        bus.mem2proc_response = 4'd4;
        smp();
        check("cold_ld_cmd", {62'd0, bus.proc2mem_command}, 64'd1);
        step();
        bus.mem2proc_response = 4'd0;
        bus.mem2proc_tag      = 4'd4;
        bus.mem2proc_data     = 64'h77;
        smp();
        check("cold_ld_fill", {63'd0, bus.cache_wr_en}, 64'd1);
        step();
        bus.mem2proc_tag  = 4'd0;
        bus.mem2proc_data = 64'd0;
`endif

        // reset while waiting; late tag must be ignored
        req(1'b0, 64'h4000, 64'd0);
        smp();
        step();
        bus.mem2proc_response = 4'd6;
        smp();
        step();
        bus.mem2proc_response = 4'd0;
        smp();
        check("rw_cmd", {62'd0, bus.proc2mem_command}, 64'd0);
        step();
        reset = 1'b1;
        smp();
        check("rw_ready", {63'd0, bus.lsq_req_ready}, 64'd1);
        check("rw_resp", {63'd0, bus.lsq_resp_valid}, 64'd0);
        step();
        reset = 1'b0;
        wc = wr_cnt;
        bus.mem2proc_tag  = 4'd6;
        bus.mem2proc_data = 64'hAAA;
        smp();
        check("late_resp", {63'd0, bus.lsq_resp_valid}, 64'd0);
        check("late_wr", {63'd0, bus.cache_wr_en}, 64'd0);
        step();
        bus.mem2proc_tag  = 4'd0;
        bus.mem2proc_data = 64'd0;
        smp();
        check("late_cnt", 64'(wr_cnt), 64'(wc));
        check("post_ready", {63'd0, bus.lsq_req_ready}, 64'd1);
        step();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Single-request data-cache controller between the load/store queue (LSQ) and `dcachemem` plus the tagged main-memory bus. It:
- latches one LSQ request at a time and looks it up in `dcachemem`;
- services load misses over the memory bus and fills the returned block into the cache;
- writes stores through to memory.

A 4-state FSM sequences the cache and the bus. Only one request is outstanding at a time.

## Interface
Parameters:
- `IDX_BITS`, 5, cache index width. Must match `DCACHE_IDX_BITS`.
- `TAG_BITS`, 56, tag width. Must equal 61-`IDX_BITS` (8-byte blocks, offset bits [2:0] ignored).

Ports:
- Clocking and reset: clock, synchronous active-high reset.
  - `clock`  in  1  clock
  - `reset`  in  1  synchronous, active-high reset
- LSQ request/response:
  - `lsq_req_valid`  in  1  request present
  - `lsq_req_store`  in  1  1 = store, 0 = load
  - `lsq_req_addr`  in  64  byte address
  - `lsq_req_data`  in  64  store data
  - `lsq_req_ready`  out  1  controller can accept a request
  - `lsq_resp_valid`  out  1  one-cycle completion pulse
  - `lsq_resp_data`  out  64  load data (0 for stores)
- Cache side (to `dcachemem`):
  - `cache_en`  out  1  cache enable
  - `cache_rd_idx`  out  IDX_BITS  lookup index
  - `cache_rd_tag`  out  TAG_BITS  lookup tag
  - `cache_rd_data`  in  64  lookup data
  - `cache_rd_valid`  in  1  lookup hit
  - `cache_wr_en`  out  1  write strobe
  - `cache_wr_idx`  out  IDX_BITS  write index
  - `cache_wr_tag`  out  TAG_BITS  write tag
  - `cache_wr_data`  out  64  write data
- Memory bus:
  - `proc2mem_command`  out  2  0 = NONE, 1 = LOAD, 2 = STORE
  - `proc2mem_addr`  out  64  block address, bits [2:0] forced to 0
  - `proc2mem_data`  out  64  store data
  - `mem2proc_response`  in  4  nonzero = request accepted, value is its transaction tag
  - `mem2proc_data`  in  64  returned data
  - `mem2proc_tag`  in  4  nonzero = data for that transaction tag is valid this cycle

## Operation
Latched registers:
- `r_store`, `r_addr`, `r_data`, `r_mtag[3:0]`.
- Index = `r_addr[IDX_BITS+2:3]`; tag = `r_addr[63:IDX_BITS+3]`.

States:
- **IDLE**
  - `lsq_req_ready`=1.
  - On `lsq_req_valid`: latch the request and go to LOOKUP.
- **LOOKUP**
  - Drive `cache_en`=1, `cache_rd_idx`/`cache_rd_tag` from the latched address, `cache_wr_en`=0.
  - Load hit (`cache_rd_valid`=1): `lsq_resp_valid`=1, `lsq_resp_data`=`cache_rd_data`, go to IDLE.
  - Load miss: go to MEMREQ.
  - Store: go to MEMREQ. Cache is untouched this cycle.
- **MEMREQ**
  - Drive `proc2mem_command` (LOAD or STORE), `proc2mem_addr`, `proc2mem_data`=`r_data`.
  - `mem2proc_response`=0: stay and re-issue every cycle.
  - Nonzero, load: `r_mtag` ← response, go to WAIT.
  - Nonzero, store:
    - cache write per Configuration (`cache_en`=1, `cache_wr_en`=1, data `r_data`);
    - `lsq_resp_valid`=1 with data 0;
    - go to IDLE.
- **WAIT**
  - `proc2mem_command`=NONE.
  - When `mem2proc_tag`==`r_mtag` (nonzero): fill the block with `cache_en`=1, `cache_wr_en`=1, `cache_wr_idx`/`cache_wr_tag` from `r_addr`, `cache_wr_data`=`mem2proc_data`.
  - Same cycle: `lsq_resp_valid`=1, `lsq_resp_data`=`mem2proc_data`, go to IDLE.
  - Any other `mem2proc_tag` value is ignored.

Rules:
- `cache_wr_en` and a cache lookup are never asserted in the same cycle.
- `proc2mem_command` is NONE outside MEMREQ.

Reset (takes priority in any state):
- state=IDLE, `lsq_req_ready`=1, `lsq_resp_valid`=0, `lsq_resp_data`=0, `proc2mem_command`=NONE, `cache_en`=`cache_wr_en`=0, all latches 0.
- Any transaction in flight is abandoned; a late `mem2proc_tag` for it is ignored because `r_mtag`=0.

## Timing
- Request accepted at edge E (IDLE and `lsq_req_valid`).
- Hit: response valid in cycle E+1, combinational from the cache read.
- Miss: bus command first driven in cycle E+2. Response arrives in the cycle the matching `mem2proc_tag` appears; the fill is written at the end of that cycle.
- Store: response in the cycle `mem2proc_response` is nonzero (E+2 at the earliest).
- `lsq_req_ready` is 0 from E+1 until IDLE is re-entered. A new request can be accepted the edge after a response.
- All state updates and cache writes occur on the rising edge of `clock`.

## Configuration
- `DCACHE_WRITE_ALLOCATE_EN` defined: every store writes `r_data`/tag into the cache in its MEMREQ-accept cycle, whether or not it hit.
- Not defined: the store hit result is registered in LOOKUP, and the cache is written only if the lookup hit. A store miss leaves the cache unchanged.

## Test plan
- After reset: `lsq_req_ready`=1, `proc2mem_command`=0, `lsq_resp_valid`=0.
- Load miss on 0x1000:
  - memory answers response=3 at once, returns tag=3 data=0xDEAD 5 cycles later;
  - required: response data=0xDEAD on that cycle, cache written at idx 0;
  - re-load of 0x1000 hits with response at E+1.
- Memory rejects (response=0) for 3 cycles: controller holds LOAD and address stable, then advances on the 4th.
- In WAIT with `r_mtag`=5, `mem2proc_tag`=2 arrives: no response and no cache write. Tag 5 next cycle completes the load.
- Store to a cold address 0x2008 with data 0x55:
  - with `DCACHE_WRITE_ALLOCATE_EN`, a following load of 0x2008 hits returning 0x55;
  - without it, the load misses and goes to the bus.
- Reset asserted in WAIT: controller returns to IDLE; a later `mem2proc_tag` matching the old tag produces no response and no cache write.
